gf_inv_checker: RTL and testbench

Bit-serial GF(2^7) multiply-and-compare engine that takes an operand and a claimed inverse, computes their product modulo f(x) = x^7+x^5+x^4+x^3+x^2+x+1, and flags whether the product equals 1. It sits downstream of the Euclidean inversion datapath. It closes the loop on every result the inverter produces and keeps running pass/fail statistics for silicon and FPGA self-test.

---
 rtl/gf_pkg.sv | 21 ++
 rtl/gf_mul_step.sv | 27 ++
 rtl/gf_inv_checker.sv | 125 ++++++++++++
 tb/tb_gf_inv_checker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^7) definitions for the inversion datapath and its checker.
// Holds the field degree, reduction polynomial, checker FSM state encoding
// and a few precomputed field constants.
package gf_pkg;

  localparam int unsigned M = 7;
  // f(x) = x^7 + x^5 + x^4 + x^3 + x^2 + x + 1, including the x^M term
  localparam logic [M:0] F_POLY = 8'b10111111;

  // x^-1 mod f: (f(x) + 1) / x
  localparam logic [M-1:0] X_INV = 7'b1011111;
  // x^7 mod f: the low M bits of f(x)
  localparam logic [M-1:0] X_M = 7'b0111111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/gf_mul_step.sv
// One MSB-first step of a bit-serial GF(2^M) multiply.
//   i_acc : running partial product
//   i_a   : multiplicand
//   i_bit : current multiplier bit
//   o_acc : (i_acc * x mod f) ^ (i_bit ? i_a : 0)
// Purely combinational so a parallel multiplier can chain M copies.
module gf_mul_step #(
  parameter int unsigned      M      = gf_pkg::M,
  parameter logic [M:0]       F_POLY = gf_pkg::F_POLY
) (
  input  logic [M-1:0] i_acc,
  input  logic [M-1:0] i_a,
  input  logic         i_bit,
  output logic [M-1:0] o_acc
);

  logic [M:0]   w_shift;
  logic [M-1:0] w_red;

  always_comb begin
    w_shift = {i_acc, 1'b0};
    // An x^M term that falls out of the top is folded back via f(x)
    w_red   = w_shift[M] ? (w_shift[M-1:0] ^ F_POLY[M-1:0]) : w_shift[M-1:0];
    o_acc   = i_bit ? (w_red ^ i_a) : w_red;
  end

endmodule

// File: rtl/gf_inv_checker.sv
// Bit-serial GF(2^M) multiply-and-compare engine. Multiplies an operand by
// its claimed inverse and flags whether the product is 1. Keeps saturating
// pass/fail counters of retired results.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b: operand pair handshake (accepted in IDLE only)
//   out_valid/out_ready        : result handshake (held in DONE)
//   out_prod/out_pass/out_zero_err : latched result of the last multiply
//   pass_cnt/fail_cnt          : saturating statistics, updated on retire
module gf_inv_checker
  import gf_pkg::*;
#(
  parameter int unsigned M      = gf_pkg::M,
  parameter logic [M:0]  F_POLY = gf_pkg::F_POLY,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_a,
  input  logic [M-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_prod,
  output logic             out_pass,
  output logic             out_zero_err,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int unsigned KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [M-1:0] One = {{(M-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_next;
  logic [M-1:0]     r_a, r_b, r_acc;
  logic [KW-1:0]    r_k;
  logic [M-1:0]     r_prod;
  logic             r_pass, r_zero;
  logic [CNT_W-1:0] r_pass_cnt, r_fail_cnt;
  logic [M-1:0]     w_acc_next;

  gf_mul_step #(
    .M      (M),
    .F_POLY (F_POLY)
  ) u_step (
    .i_acc (r_acc),
    .i_a   (r_a),
    .i_bit (r_b[r_k]),
    .o_acc (w_acc_next)
  );

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = StMult;
      end
      StMult: begin
        if (r_k == '0) w_state_next = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_k        <= '0;
      r_prod     <= '0;
      r_pass     <= 1'b0;
      r_zero     <= 1'b0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a   <= in_a;
            r_b   <= in_b;
            r_acc <= '0;
            r_k   <= KW'(M - 1);
          end
        end
        StMult: begin
          r_acc <= w_acc_next;
          r_k   <= r_k - 1'b1;
          if (r_k == '0) begin
            r_prod <= w_acc_next;
            r_pass <= (w_acc_next == One) && (r_a != '0);
            r_zero <= (r_a == '0) || (r_b == '0);
          end
        end
        StDone: begin
          if (out_ready) begin
            // Zero-operand errors never set r_pass, so they land in fail_cnt
            if (r_pass) begin
              if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
            end else begin
              if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_prod     = r_prod;
  assign out_pass     = r_pass;
  assign out_zero_err = r_zero;
  assign pass_cnt     = r_pass_cnt;
  assign fail_cnt     = r_fail_cnt;

endmodule

// File: tb/tb_gf_inv_checker.sv
module tb_gf_inv_checker;

  localparam int unsigned M     = 7;
  localparam int unsigned CNT_W = 4;  // narrow so saturation is reachable

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [M-1:0]     in_a = '0;
  logic [M-1:0]     in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [M-1:0]     out_prod;
  logic             out_pass;
  logic             out_zero_err;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  gf_inv_checker #(
    .M      (M),
    .F_POLY (8'b10111111),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_prod     (out_prod),
    .out_pass     (out_pass),
    .out_zero_err (out_zero_err),
    .pass_cnt     (pass_cnt),
    .fail_cnt     (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] prod;
    logic         pass;
    logic         zero;
  } vec_t;

  vec_t vecs [10];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   exp_pass = 0;
  int   exp_fail = 0;
  int   cmax = (1 << CNT_W) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_txn(input logic [M-1:0] a, input logic [M-1:0] b);
    @(negedge clk);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 7'($urandom);
    in_b     = 7'($urandom);
  endtask

  // Waits for the result, checks latency and payload, then retires it.
  task automatic finish_txn(input string name, input logic [M-1:0] prod,
                            input logic pass, input logic zero, input int lat_done);
    int cyc;
    cyc = lat_done;
    while (!out_valid && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, "_latency"}, cyc, 7);
    chk({name, "_prod"}, out_prod, prod);
    chk({name, "_pass"}, out_pass, pass);
    chk({name, "_zero_err"}, out_zero_err, zero);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (pass) begin
      if (exp_pass < cmax) exp_pass++;
    end else begin
      if (exp_fail < cmax) exp_fail++;
    end
    chk({name, "_out_valid_after_retire"}, out_valid, 0);
    chk({name, "_pass_cnt"}, pass_cnt, exp_pass);
    chk({name, "_fail_cnt"}, fail_cnt, exp_fail);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_in_ready"}, in_ready, 1);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_prod"}, out_prod, 0);
    chk({name, "_out_pass"}, out_pass, 0);
    chk({name, "_out_zero_err"}, out_zero_err, 0);
    chk({name, "_pass_cnt"}, pass_cnt, 0);
    chk({name, "_fail_cnt"}, fail_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [M-1:0] held_prod;

    // a, b, a*b mod f, pass, zero_err
    vecs[0] = '{7'd2,   7'd95,  7'd1,   1'b1, 1'b0};  // x * x^-1
    vecs[1] = '{7'd2,   7'd94,  7'd3,   1'b0, 1'b0};
    vecs[2] = '{7'd64,  7'd2,   7'd63,  1'b0, 1'b0};  // x^7 mod f
    vecs[3] = '{7'd0,   7'd0,   7'd0,   1'b0, 1'b1};
    vecs[4] = '{7'd64,  7'd95,  7'd32,  1'b0, 1'b0};  // x^6 * x^-1 = x^5
    vecs[5] = '{7'd5,   7'd3,   7'd15,  1'b0, 1'b0};
    vecs[6] = '{7'd64,  7'd64,  7'd91,  1'b0, 1'b0};  // x^12 mod f
    vecs[7] = '{7'd95,  7'd2,   7'd1,   1'b1, 1'b0};
    vecs[8] = '{7'd5,   7'd0,   7'd0,   1'b0, 1'b1};
    vecs[9] = '{7'd127, 7'd1,   7'd127, 1'b0, 1'b0};

    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      start_txn(vecs[i].a, vecs[i].b);
      finish_txn($sformatf("vec%0d", i), vecs[i].prod, vecs[i].pass, vecs[i].zero, 0);
    end

    // Backpressure: result held with out_ready low, busy in_valid ignored
    start_txn(7'd2, 7'd95);
    for (int c = 0; c < 12 && !out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_out_valid", out_valid, 1);
    held_prod = out_prod;
    chk("bp_prod", held_prod, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = c[0];
      in_a     = 7'd3;
      in_b     = 7'd3;
      @(posedge clk);
      #1;
      if (c % 5 == 4) begin
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_prod", out_prod, 1);
        chk("bp_hold_pass", out_pass, 1);
        chk("bp_hold_pass_cnt", pass_cnt, exp_pass);
      end
    end
    // Retire with a new pair already offered: it must wait one more cycle
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 7'd64;
    in_b      = 7'd95;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    if (exp_pass < cmax) exp_pass++;
    chk("bp_retire_pass_cnt", pass_cnt, exp_pass);
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accept_ready", in_ready, 0);
    finish_txn("bp_next", 7'd32, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of MULT
    start_txn(7'd127, 7'd127);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_pass = 0;
    exp_fail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    start_txn(7'd1, 7'd1);
    finish_txn("after_reset", 7'd1, 1'b1, 1'b0, 0);

    // Drive fail_cnt into saturation
    for (int i = 0; i < 17; i++) begin
      start_txn(7'd0, 7'd0);
      finish_txn($sformatf("sat%0d", i), 7'd0, 1'b0, 1'b1, 0);
    end
    chk("sat_fail_cnt_final", fail_cnt, cmax);
    chk("sat_pass_cnt_final", pass_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
